// File: rtl/router_pkg.sv
// Shared router types: scheduler state encoding, port-count helpers and port index type.
`ifndef ROUTER_NUM_PORTS
`define ROUTER_NUM_PORTS 4
`endif

package router_pkg;

  localparam int NUM_PORTS = `ROUTER_NUM_PORTS;
  localparam int NP        = NUM_PORTS + 1;
  localparam int DEST_W    = $clog2(NP);

  typedef logic [DEST_W-1:0] port_idx_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    LOCKED = ST_LOCKED
  } sched_state_t;

endpackage

// File: rtl/router_sched_if.sv
// Scheduler handshake bundle between ingress/egress FIFO control and the crossbar scheduler.
interface router_sched_if
  import router_pkg::*;
#(
  parameter int NP     = router_pkg::NP,
  parameter int DEST_W = router_pkg::DEST_W
);

  logic [NP-1:0]        in_req;
  logic [NP*DEST_W-1:0] in_dest;
  logic [NP-1:0]        in_last;
  logic [NP-1:0]        out_rdy;
  logic [NP-1:0]        in_pop;
  logic [NP-1:0]        out_push;
  logic [NP*DEST_W-1:0] out_sel;
  logic [NP-1:0]        out_busy;
  logic [NP-1:0]        err_dest;

  modport master (
    output in_req, in_dest, in_last, out_rdy,
    input  in_pop, out_push, out_sel, out_busy, err_dest
  );

  modport slave (
    input  in_req, in_dest, in_last, out_rdy,
    output in_pop, out_push, out_sel, out_busy, err_dest
  );

endinterface

// File: rtl/router_sched_rr_arbiter.sv
// Combinational round-robin pick: first request found scanning upward from ptr+1, wrapping at NP.
// Returns a one-hot grant (all zero when nothing requests) and the encoded winner index.
module rr_arbiter #(
  parameter int NP    = 5,
  parameter int IDX_W = 3
) (
  input  logic [NP-1:0]    req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NP-1:0]    gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] c;

  // Scan farthest-first so the nearest requester after ptr overwrites earlier picks.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = '0;
    for (int k = NP; k >= 1; k--) begin
      c = IDX_W'((int'(ptr) + k) % NP);
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/router_sched.sv
// Crossbar scheduler: per-egress round-robin arbitration with wormhole locks, grant one edge after header.
// Transfers stall in place on out_rdy/in_req low; pop/push/err are combinational, sel/busy registered.
`ifndef ROUTER_NUM_PORTS
`define ROUTER_NUM_PORTS 4
`endif

module router_sched
  import router_pkg::*;
#(
  parameter int NUM_PORTS = `ROUTER_NUM_PORTS,
  parameter int DEST_W    = $clog2(NUM_PORTS + 1)
) (
  input  logic          clk,
  input  logic          arst,
  router_sched_if.slave bus
);

  localparam int NPORTS = NUM_PORTS + 1;

  sched_state_t      state_q   [NPORTS];
  sched_state_t      state_d   [NPORTS];
  logic [DEST_W-1:0] ptr_q     [NPORTS];
  logic [DEST_W-1:0] ptr_d     [NPORTS];
  logic [DEST_W-1:0] out_sel_q [NPORTS];
  logic [DEST_W-1:0] out_sel_d [NPORTS];
  logic [DEST_W-1:0] dest      [NPORTS];
  logic [NPORTS-1:0] cand      [NPORTS];
  logic [NPORTS-1:0] gnt       [NPORTS];
  logic [DEST_W-1:0] win_idx   [NPORTS];
  logic [NPORTS-1:0] locked;
  logic [NPORTS-1:0] in_pop;
  logic [NPORTS-1:0] out_push;
  logic [NPORTS-1:0] err_dest;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      dest[i] = bus.in_dest[i*DEST_W +: DEST_W];
    end
  end

  // Lock mask comes only from registered state, so a release takes effect one cycle later.
  always_comb begin
    locked = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (state_q[o] == LOCKED) begin
        locked[out_sel_q[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    err_dest = '0;
    for (int o = 0; o < NPORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        cand[o][i] = bus.in_req[i] & ~locked[i] & (dest[i] == DEST_W'(o));
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      err_dest[i] = bus.in_req[i] & ~locked[i] & (int'(dest[i]) >= NPORTS);
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_arb
    rr_arbiter #(
      .NP    (NPORTS),
      .IDX_W (DEST_W)
    ) u_arb (
      .req (cand[g]),
      .ptr (ptr_q[g]),
      .gnt (gnt[g]),
      .idx (win_idx[g])
    );
  end

  always_comb begin
    in_pop   = '0;
    out_push = '0;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o]   = state_q[o];
      ptr_d[o]     = ptr_q[o];
      out_sel_d[o] = out_sel_q[o];
      if (state_q[o] == IDLE) begin
        if (|gnt[o]) begin
          state_d[o]   = LOCKED;
          ptr_d[o]     = win_idx[o];
          out_sel_d[o] = win_idx[o];
        end
      end else if (bus.in_req[out_sel_q[o]] && bus.out_rdy[o]) begin
        out_push[o]           = 1'b1;
        in_pop[out_sel_q[o]]  = 1'b1;
        if (bus.in_last[out_sel_q[o]]) begin
          state_d[o] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o]   <= IDLE;
        ptr_q[o]     <= DEST_W'(NPORTS - 1);
        out_sel_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o]   <= state_d[o];
        ptr_q[o]     <= ptr_d[o];
        out_sel_q[o] <= out_sel_d[o];
      end
    end
  end

  always_comb begin
    bus.out_sel  = '0;
    bus.out_busy = '0;
    for (int o = 0; o < NPORTS; o++) begin
      bus.out_sel[o*DEST_W +: DEST_W] = out_sel_q[o];
      bus.out_busy[o]                 = (state_q[o] == LOCKED);
    end
  end

  assign bus.in_pop   = in_pop;
  assign bus.out_push = out_push;
  assign bus.err_dest = err_dest;

endmodule
